// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - debounced BCD up/down event counter with multiplexed 7-seg scan driver
// Optional leading-zero blanking: define BCD_SCAN_LZB_EN.
module bcd_scan_counter #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cnt_in,
    input  logic                  en,
    input  logic                  up_down,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   value,
    output logic                  co,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     sel
);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [1:0]          r_sync;
    logic                r_deb;
    logic                r_deb_d;
    logic [DEB_W-1:0]    r_stab;
    logic                r_strobe;
    logic [4*DIGITS-1:0] r_value;
    logic                r_co;
    logic [DIV_W-1:0]    r_div;
    logic [IDX_W-1:0]    r_idx;
    logic [DIGITS-1:0]   r_sel;
    logic [7:0]          r_seg;

    logic [4*DIGITS-1:0] w_inc;
    logic [4*DIGITS-1:0] w_dec;
    logic [4*DIGITS-1:0] w_load;
    logic                w_carry;
    logic                w_borrow;
    logic [IDX_W-1:0]    w_idx_next;
    logic [3:0]          w_digit;
    logic                w_blank;
    logic [7:0]          w_seg;

    // Debounced level flips only after DEB_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync   <= 2'b00;
            r_deb    <= 1'b0;
            r_deb_d  <= 1'b0;
            r_stab   <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], cnt_in};
            r_deb_d  <= r_deb;
            r_strobe <= r_deb & ~r_deb_d;
            if (r_sync[1] == r_deb) begin
                r_stab <= '0;
            end else if (r_stab == DEB_W'(DEB_CYCLES - 1)) begin
                r_deb  <= ~r_deb;
                r_stab <= '0;
            end else begin
                r_stab <= r_stab + 1'b1;
            end
        end
    end

    always_comb begin
        w_carry  = 1'b1;
        w_borrow = 1'b1;
        w_inc    = r_value;
        w_dec    = r_value;
        w_load   = load_val;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_carry) begin
                if (r_value[4*k +: 4] >= 4'd9) begin
                    w_inc[4*k +: 4] = 4'd0;
                end else begin
                    w_inc[4*k +: 4] = r_value[4*k +: 4] + 4'd1;
                    w_carry         = 1'b0;
                end
            end
            if (w_borrow) begin
                if (r_value[4*k +: 4] == 4'd0) begin
                    w_dec[4*k +: 4] = 4'd9;
                end else begin
                    w_dec[4*k +: 4] = r_value[4*k +: 4] - 4'd1;
                    w_borrow        = 1'b0;
                end
            end
            if (load_val[4*k +: 4] > 4'd9) begin
                w_load[4*k +: 4] = 4'd9;
            end
        end
    end

    // A carry/borrow surviving past the top digit is the full-width wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_value <= '0;
            r_co    <= 1'b0;
        end else begin
            r_co <= 1'b0;
            if (load) begin
                r_value <= w_load;
            end else if (r_strobe && en) begin
                if (up_down) begin
                    r_value <= w_inc;
                    r_co    <= w_carry;
                end else begin
                    r_value <= w_dec;
                    r_co    <= w_borrow;
                end
            end
        end
    end

    always_comb begin
        w_idx_next = r_idx;
        if (r_div == DIV_W'(SCAN_DIV - 1)) begin
            w_idx_next = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end
    end

    assign w_digit = r_value[{w_idx_next, 2'b00} +: 4];

`ifdef BCD_SCAN_LZB_EN
    logic [4*DIGITS-1:0] w_upper;
    assign w_upper = r_value >> {w_idx_next, 2'b00};
    assign w_blank = (w_idx_next != '0) && (w_upper == '0);
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_seg = 8'hff;
        if (!w_blank) begin
            case (w_digit)
                4'd0:    w_seg = 8'hc0;
                4'd1:    w_seg = 8'hf9;
                4'd2:    w_seg = 8'ha4;
                4'd3:    w_seg = 8'hb0;
                4'd4:    w_seg = 8'h99;
                4'd5:    w_seg = 8'h92;
                4'd6:    w_seg = 8'h82;
                4'd7:    w_seg = 8'hf8;
                4'd8:    w_seg = 8'h80;
                4'd9:    w_seg = 8'h90;
                default: w_seg = 8'hff;
            endcase
        end
    end

    // sel and seg both derive from the next index so they switch on the same edge as r_idx
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= '0;
            r_sel <= ~DIGITS'(1);
            r_seg <= 8'hc0;
        end else begin
            r_div <= (r_div == DIV_W'(SCAN_DIV - 1)) ? '0 : r_div + 1'b1;
            r_idx <= w_idx_next;
            r_sel <= ~(DIGITS'(1) << w_idx_next);
            r_seg <= w_seg;
        end
    end

    assign value = r_value;
    assign co    = r_co;
    assign seg   = r_seg;
    assign sel   = r_sel;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb/tb_bcd_scan_counter.sv - randomized self-checking bench for bcd_scan_counter against an integer model
module tb_bcd_scan_counter;
    localparam int DIGITS     = 4;
    localparam int SCAN_DIV   = 3;
    localparam int DEB_CYCLES = 4;
    localparam int MODV       = 10000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cnt_in = 1'b0;
    logic        en = 1'b1;
    logic        up_down = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] value;
    logic        co;
    logic [7:0]  seg;
    logic [3:0]  sel;

    int n_cmp = 0;
    int n_bad = 0;
    int model_v = 0;

    always #5 clk = ~clk;

    bcd_scan_counter #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .en(en), .up_down(up_down),
        .load(load), .load_val(load_val), .value(value), .co(co), .seg(seg), .sel(sel)
    );

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_seg(input int v, input int k);
        int p;
        int d;
        p = 1;
        for (int j = 0; j < k; j++) p = p * 10;
        d = (v / p) % 10;
`ifdef BCD_SCAN_LZB_EN
        if (k > 0 && v < p) return 8'hff;
`endif
        case (d)
            0: return 8'hc0;
            1: return 8'hf9;
            2: return 8'ha4;
            3: return 8'hb0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hf8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hff;
        endcase
    endfunction

    task automatic drive_load(input int d3, input int d2, input int d1, input int d0);
        load_val = {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        model_v = (d3 > 9 ? 9 : d3) * 1000 + (d2 > 9 ? 9 : d2) * 100 + (d1 > 9 ? 9 : d1) * 10 + (d0 > 9 ? 9 : d0);
    endtask

    task automatic press(input int hold, input int rel, output int co_cnt, output int first_change,
                         output logic [15:0] co_val);
        logic [15:0] v0;
        v0 = value;
        co_cnt = 0;
        first_change = -1;
        co_val = 'x;
        cnt_in = 1'b1;
        for (int i = 1; i <= hold + rel; i++) begin
            @(negedge clk);
            if (co === 1'b1) begin
                co_cnt++;
                co_val = value;
            end
            if (first_change < 0 && value !== v0) first_change = i;
            if (i == hold) cnt_in = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cnt_in = ~cnt_in;
            @(negedge clk);
        end
        n_cmp++; if (value !== 16'h0000) begin n_bad++; $display("FAIL reset_value: got %h want 0000", value); end
        n_cmp++; if (co !== 1'b0) begin n_bad++; $display("FAIL reset_co: got %b want 0", co); end
        n_cmp++; if (sel !== 4'b1110) begin n_bad++; $display("FAIL reset_sel: got %b want 1110", sel); end
        n_cmp++; if (seg !== 8'hc0) begin n_bad++; $display("FAIL reset_seg: got %h want c0", seg); end
        rst_n = 1'b1;
        cnt_in = 1'b0;
        model_v = 0;
        repeat (DEB_CYCLES + 6) @(negedge clk);
    endtask

    task automatic test_up_wrap;
        int cc, fc;
        logic [15:0] cv;
        en = 1'b1;
        up_down = 1'b1;
        drive_load(9, 9, 9, 8);
        press(DEB_CYCLES + 4, DEB_CYCLES + 6, cc, fc, cv);
        n_cmp++; if (value !== 16'h9999) begin n_bad++; $display("FAIL up_first: got %h want 9999", value); end
        n_cmp++; if (cc !== 0) begin n_bad++; $display("FAIL up_first_co: got %0d pulses want 0", cc); end
        n_cmp++; if (fc !== DEB_CYCLES + 4) begin n_bad++; $display("FAIL count_latency: got %0d want %0d", fc, DEB_CYCLES + 4); end
        press(DEB_CYCLES + 4, DEB_CYCLES + 6, cc, fc, cv);
        n_cmp++; if (value !== 16'h0000) begin n_bad++; $display("FAIL up_wrap: got %h want 0000", value); end
        n_cmp++; if (cc !== 1) begin n_bad++; $display("FAIL up_wrap_co: got %0d pulses want 1", cc); end
        n_cmp++; if (cv !== 16'h0000) begin n_bad++; $display("FAIL up_wrap_co_align: got %h want 0000", cv); end
        model_v = 0;
    endtask

    task automatic test_down_borrow;
        int cc, fc;
        logic [15:0] cv;
        up_down = 1'b0;
        drive_load(0, 0, 1, 0);
        press(DEB_CYCLES + 4, DEB_CYCLES + 6, cc, fc, cv);
        n_cmp++; if (value !== 16'h0009) begin n_bad++; $display("FAIL down_ripple: got %h want 0009", value); end
        n_cmp++; if (cc !== 0) begin n_bad++; $display("FAIL down_ripple_co: got %0d pulses want 0", cc); end
        drive_load(0, 0, 0, 0);
        press(DEB_CYCLES + 4, DEB_CYCLES + 6, cc, fc, cv);
        n_cmp++; if (value !== 16'h9999) begin n_bad++; $display("FAIL down_wrap: got %h want 9999", value); end
        n_cmp++; if (cc !== 1) begin n_bad++; $display("FAIL down_wrap_co: got %0d pulses want 1", cc); end
        n_cmp++; if (cv !== 16'h9999) begin n_bad++; $display("FAIL down_wrap_co_align: got %h want 9999", cv); end
        model_v = 9999;
        up_down = 1'b1;
    endtask

    task automatic test_debounce;
        int cc, fc;
        logic [15:0] cv;
        drive_load(0, 0, 4, 2);
        cnt_in = 1'b1;
        repeat (3) @(negedge clk);
        cnt_in = 1'b0;
        repeat (DEB_CYCLES + 6) @(negedge clk);
        n_cmp++; if (value !== 16'h0042) begin n_bad++; $display("FAIL glitch: got %h want 0042", value); end
        for (int i = 1; i <= 12; i++) begin
            cnt_in = (i == 2) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        cnt_in = 1'b0;
        repeat (DEB_CYCLES + 6) @(negedge clk);
        n_cmp++; if (value !== 16'h0043) begin n_bad++; $display("FAIL bounce: got %h want 0043", value); end
        en = 1'b0;
        press(DEB_CYCLES + 4, DEB_CYCLES + 6, cc, fc, cv);
        n_cmp++; if (value !== 16'h0043) begin n_bad++; $display("FAIL en_off: got %h want 0043", value); end
        n_cmp++; if (cc !== 0) begin n_bad++; $display("FAIL en_off_co: got %0d pulses want 0", cc); end
        en = 1'b1;
        model_v = 43;
    endtask

    task automatic test_scan;
        int prev_pos, run, pos, zeros;
        bit seen_change;
        prev_pos = -1;
        run = 0;
        seen_change = 0;
        for (int i = 0; i < 3 * DIGITS * SCAN_DIV; i++) begin
            @(negedge clk);
            zeros = 0;
            pos = 0;
            for (int k = 0; k < DIGITS; k++) if (sel[k] === 1'b0) begin zeros++; pos = k; end
            n_cmp++; if (zeros !== 1) begin n_bad++; $display("FAIL scan_onehot: sel %b", sel); end
            if (pos != prev_pos) begin
                if (prev_pos >= 0) begin
                    n_cmp++; if (pos !== (prev_pos + 1) % DIGITS) begin n_bad++; $display("FAIL scan_order: got %0d want %0d", pos, (prev_pos + 1) % DIGITS); end
                    if (seen_change) begin
                        n_cmp++; if (run !== SCAN_DIV) begin n_bad++; $display("FAIL scan_dwell: got %0d want %0d", run, SCAN_DIV); end
                    end
                    seen_change = 1;
                end
                prev_pos = pos;
                run = 1;
            end else begin
                run++;
            end
            n_cmp++; if (seg !== exp_seg(model_v, pos)) begin n_bad++; $display("FAIL scan_seg pos %0d: got %h want %h", pos, seg, exp_seg(model_v, pos)); end
        end
    endtask

    task automatic test_scan_1234;
        drive_load(1, 2, 3, 4);
        test_scan();
    endtask

    task automatic test_load_priority;
        int cc;
        cc = 0;
        en = 1'b1;
        up_down = 1'b1;
        cnt_in = 1'b1;
        for (int i = 1; i <= 2 * DEB_CYCLES + 10; i++) begin
            @(negedge clk);
            if (co === 1'b1) cc++;
            if (i == DEB_CYCLES + 3) begin
                load_val = 16'h00a5;
                load = 1'b1;
            end
            if (i == DEB_CYCLES + 4) begin
                load = 1'b0;
                n_cmp++; if (value !== 16'h0095) begin n_bad++; $display("FAIL load_clamp: got %h want 0095", value); end
            end
            if (i == DEB_CYCLES + 4) cnt_in = 1'b0;
        end
        model_v = 95;
        n_cmp++; if (value !== 16'h0095) begin n_bad++; $display("FAIL load_priority: got %h want 0095", value); end
        n_cmp++; if (cc !== 0) begin n_bad++; $display("FAIL load_priority_co: got %0d pulses want 0", cc); end
        test_scan();
    endtask

    task automatic test_mid_reset;
        drive_load(0, 0, 0, 7);
        cnt_in = 1'b1;
        repeat (DEB_CYCLES + 3) @(negedge clk);
        rst_n = 1'b0;
        cnt_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_v = 0;
        n_cmp++; if (value !== 16'h0000) begin n_bad++; $display("FAIL midreset_value: got %h want 0000", value); end
        n_cmp++; if (sel !== 4'b1110) begin n_bad++; $display("FAIL midreset_sel: got %b want 1110", sel); end
        n_cmp++; if (seg !== 8'hc0) begin n_bad++; $display("FAIL midreset_seg: got %h want c0", seg); end
        for (int i = 0; i < DEB_CYCLES + 6; i++) begin
            @(negedge clk);
            n_cmp++; if (co !== 1'b0 || value !== 16'h0000) begin n_bad++; $display("FAIL midreset_discard: value %h co %b want 0000 0", value, co); end
        end
    endtask

    task automatic test_random;
        int cc, fc, exp_co, d[4];
        logic [15:0] cv;
        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < 4; k++) d[k] = $urandom_range(0, 15);
                drive_load(d[3], d[2], d[1], d[0]);
                n_cmp++; if (value !== to_bcd(model_v)) begin n_bad++; $display("FAIL rand_load: got %h want %h", value, to_bcd(model_v)); end
            end else begin
                if ($urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 1) == 0) drive_load(9, 9, 9, 9);
                    else drive_load(0, 0, 0, 0);
                end
                en = ($urandom_range(0, 3) != 0);
                up_down = $urandom_range(0, 1);
                exp_co = 0;
                if (en) begin
                    if (up_down) begin
                        if (model_v == MODV - 1) exp_co = 1;
                        model_v = (model_v + 1) % MODV;
                    end else begin
                        if (model_v == 0) exp_co = 1;
                        model_v = (model_v + MODV - 1) % MODV;
                    end
                end
                press(DEB_CYCLES + $urandom_range(4, 8), DEB_CYCLES + $urandom_range(4, 8), cc, fc, cv);
                n_cmp++; if (value !== to_bcd(model_v)) begin n_bad++; $display("FAIL rand_value it %0d: got %h want %h", it, value, to_bcd(model_v)); end
                n_cmp++; if (cc !== exp_co) begin n_bad++; $display("FAIL rand_co it %0d: got %0d pulses want %0d", it, cc, exp_co); end
                if (exp_co == 1) begin
                    n_cmp++; if (cv !== to_bcd(model_v)) begin n_bad++; $display("FAIL rand_co_align it %0d: got %h want %h", it, cv, to_bcd(model_v)); end
                end
            end
        end
        en = 1'b1;
        up_down = 1'b1;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_borrow();
        test_debounce();
        test_scan_1234();
        test_load_priority();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
